// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the ID/EX pipeline register slice: field widths,
// ALU operation encodings, the control-bit bundle, the full ID/EX stage
// record and the bubble constant used by reset, flush and stall.
// Also holds the per-edge update selector used by the top's priority logic.
// Optional feature macro used by the top: ID_EX_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;
    localparam int DATA_W     = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // All-zero control word: writes nothing, touches no memory.
    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] wr_addr;
        ctrl_t                 ctrl;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc_plus4;
    } id_ex_t;

    // Bubble clears register addresses too, so forwarding compares never hit.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // What the stage register does on the coming edge (reset handled apart).
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_FLUSH  = 2'd2,
        UPD_STALL  = 2'd3
    } upd_sel_e;

    function automatic logic [REG_ADDR_W-1:0] sel_dest(
        input logic                  reg_dst,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rt
    );
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare between the instruction sitting
// in ID/EX and the instruction currently decoded in ID.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_wr_addr_i : state of the ID/EX register
//   id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i : decoded instruction in ID
//   hazard_o : ID consumes a register the load in EX has not produced yet
// -----------------------------------------------------------------------------
module load_use_detect
    import mips_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  hazard_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_wr_addr_i != '0);
    assign rs_match   = (ex_wr_addr_i == id_rs_i);
    assign rt_match   = id_uses_rt_i & (ex_wr_addr_i == id_rt_i);
    assign hazard_o   = ex_is_load & id_valid_i & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_reg
// ID/EX pipeline register with load-use stall, pipeline hold and branch flush.
// Edge priority: reset > ex_flush > pipe_hold > load-use stall > normal load.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   id_*                          : decoded instruction fields from ID
//   ex_flush                      : taken branch/jump, replace contents with bubble
//   pipe_hold                     : downstream wait, freeze stage and upstream
//   id_ex_*                       : registered copies, one cycle latency
//   pc_write, if_id_write         : upstream advance enables
//   load_use_stall                : hazard seen this cycle
//   stall_count, flush_count      : saturating event counters (macro only)
// Build option: define ID_EX_PERF_CNT_EN to add the two event counters.
// -----------------------------------------------------------------------------
module id_ex_pipeline_reg
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_instr_rs,
    input  logic [REG_ADDR_W-1:0] id_instr_rt,
    input  logic [REG_ADDR_W-1:0] id_instr_rd,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_alu_src,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc_plus4,

    input  logic                  ex_flush,
    input  logic                  pipe_hold,

    output logic                  id_ex_valid,
    output logic [REG_ADDR_W-1:0] id_ex_instr_rs,
    output logic [REG_ADDR_W-1:0] id_ex_instr_rt,
    output logic [REG_ADDR_W-1:0] id_ex_write_reg_addr,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_mem_to_reg,
    output logic                  id_ex_alu_src,
    output logic [ALU_OP_W-1:0]   id_ex_alu_op,
    output logic [DATA_W-1:0]     id_ex_rs_data,
    output logic [DATA_W-1:0]     id_ex_rt_data,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [DATA_W-1:0]     id_ex_pc_plus4,

    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  load_use_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    id_ex_t   stage_q;
    id_ex_t   stage_d;
    id_ex_t   id_capture;
    upd_sel_e upd_sel;
    logic     hazard;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (stage_q.valid),
        .ex_mem_read_i (stage_q.ctrl.mem_read),
        .ex_wr_addr_i  (stage_q.wr_addr),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_instr_rs),
        .id_rt_i       (id_instr_rt),
        .id_uses_rt_i  (id_uses_rt),
        .hazard_o      (hazard)
    );

    // Image of the ID instruction; an empty ID slot becomes a bubble.
    always_comb begin
        id_capture = ID_EX_BUBBLE;
        if (id_valid) begin
            id_capture.valid           = 1'b1;
            id_capture.rs              = id_instr_rs;
            id_capture.rt              = id_instr_rt;
            id_capture.wr_addr         = sel_dest(id_reg_dst, id_instr_rd, id_instr_rt);
            id_capture.ctrl.reg_write  = id_reg_write;
            id_capture.ctrl.mem_read   = id_mem_read;
            id_capture.ctrl.mem_write  = id_mem_write;
            id_capture.ctrl.mem_to_reg = id_mem_to_reg;
            id_capture.ctrl.alu_src    = id_alu_src;
            id_capture.ctrl.alu_op     = id_alu_op;
            id_capture.rs_data         = id_rs_data;
            id_capture.rt_data         = id_rt_data;
            id_capture.imm             = id_imm;
            id_capture.pc_plus4        = id_pc_plus4;
        end
    end

    always_comb begin
        upd_sel = UPD_LOAD;
        if (ex_flush) begin
            upd_sel = UPD_FLUSH;
        end else if (pipe_hold) begin
            upd_sel = UPD_HOLD;
        end else if (hazard) begin
            upd_sel = UPD_STALL;
        end
    end

    always_comb begin
        stage_d = stage_q;
        case (upd_sel)
            UPD_FLUSH: stage_d = ID_EX_BUBBLE;
            UPD_HOLD:  stage_d = stage_q;
            UPD_STALL: stage_d = ID_EX_BUBBLE;
            default:   stage_d = id_capture;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= ID_EX_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Flush keeps upstream moving so the branch redirect is taken even when
    // a stall or hold is also pending; reset likewise releases upstream.
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        load_use_stall = hazard & ~reset;
        if (!reset && (upd_sel == UPD_HOLD || upd_sel == UPD_STALL)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

    assign id_ex_valid          = stage_q.valid;
    assign id_ex_instr_rs       = stage_q.rs;
    assign id_ex_instr_rt       = stage_q.rt;
    assign id_ex_write_reg_addr = stage_q.wr_addr;
    assign id_ex_reg_write      = stage_q.ctrl.reg_write;
    assign id_ex_mem_read       = stage_q.ctrl.mem_read;
    assign id_ex_mem_write      = stage_q.ctrl.mem_write;
    assign id_ex_mem_to_reg     = stage_q.ctrl.mem_to_reg;
    assign id_ex_alu_src        = stage_q.ctrl.alu_src;
    assign id_ex_alu_op         = stage_q.ctrl.alu_op;
    assign id_ex_rs_data        = stage_q.rs_data;
    assign id_ex_rt_data        = stage_q.rt_data;
    assign id_ex_imm            = stage_q.imm;
    assign id_ex_pc_plus4       = stage_q.pc_plus4;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Counts only edges where the event actually shapes the stage contents.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (upd_sel == UPD_STALL && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (upd_sel == UPD_FLUSH && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_instr_rs, id_instr_rt, id_instr_rd;
    logic        id_uses_rt, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic        ex_flush, pipe_hold;

    logic        id_ex_valid;
    logic [4:0]  id_ex_instr_rs, id_ex_instr_rt, id_ex_write_reg_addr;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src;
    logic [3:0]  id_ex_alu_op;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc_plus4;
    logic        pc_write, if_id_write, load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk                  (clk),
        .reset                (reset),
        .id_valid             (id_valid),
        .id_instr_rs          (id_instr_rs),
        .id_instr_rt          (id_instr_rt),
        .id_instr_rd          (id_instr_rd),
        .id_uses_rt           (id_uses_rt),
        .id_reg_dst           (id_reg_dst),
        .id_reg_write         (id_reg_write),
        .id_mem_read          (id_mem_read),
        .id_mem_write         (id_mem_write),
        .id_mem_to_reg        (id_mem_to_reg),
        .id_alu_src           (id_alu_src),
        .id_alu_op            (id_alu_op),
        .id_rs_data           (id_rs_data),
        .id_rt_data           (id_rt_data),
        .id_imm               (id_imm),
        .id_pc_plus4          (id_pc_plus4),
        .ex_flush             (ex_flush),
        .pipe_hold            (pipe_hold),
        .id_ex_valid          (id_ex_valid),
        .id_ex_instr_rs       (id_ex_instr_rs),
        .id_ex_instr_rt       (id_ex_instr_rt),
        .id_ex_write_reg_addr (id_ex_write_reg_addr),
        .id_ex_reg_write      (id_ex_reg_write),
        .id_ex_mem_read       (id_ex_mem_read),
        .id_ex_mem_write      (id_ex_mem_write),
        .id_ex_mem_to_reg     (id_ex_mem_to_reg),
        .id_ex_alu_src        (id_ex_alu_src),
        .id_ex_alu_op         (id_ex_alu_op),
        .id_ex_rs_data        (id_ex_rs_data),
        .id_ex_rt_data        (id_ex_rt_data),
        .id_ex_imm            (id_ex_imm),
        .id_ex_pc_plus4       (id_ex_pc_plus4),
        .pc_write             (pc_write),
        .if_id_write          (if_id_write),
        .load_use_stall       (load_use_stall)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_count          (stall_count),
        .flush_count          (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic uses_rt, input logic reg_dst,
                         input logic rw, input logic mr, input logic m2r, input logic asrc,
                         input logic [3:0] op, input logic [31:0] imm);
        id_valid      = v;
        id_instr_rs   = rs;
        id_instr_rt   = rt;
        id_instr_rd   = rd;
        id_uses_rt    = uses_rt;
        id_reg_dst    = reg_dst;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_mem_write  = 1'b0;
        id_mem_to_reg = m2r;
        id_alu_src    = asrc;
        id_alu_op     = op;
        id_rs_data    = 32'hDEAD_0000 | {27'd0, rs};
        id_rt_data    = 32'hBEEF_0000 | {27'd0, rt};
        id_imm        = imm;
        id_pc_plus4   = 32'h0000_4000;
    endtask

    // lw rt, imm(rs)
    task automatic drv_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        drive(1'b1, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, imm);
    endtask

    task automatic drv_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic drv_sub(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'd0);
    endtask

    // addi rt, rs, imm : rt is a destination, not a source
    task automatic drv_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        drive(1'b1, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, imm);
    endtask

    initial begin
        reset     = 1'b1;
        ex_flush  = 1'b0;
        pipe_hold = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        tick();

        // reset state
        chk("rst_valid", 32'(id_ex_valid), 0);
        chk("rst_wr", 32'(id_ex_write_reg_addr), 0);
        chk("rst_rs_data", id_ex_rs_data, 0);
        chk("rst_stall", 32'(load_use_stall), 0);
        chk("rst_pcw", 32'(pc_write), 1);
        chk("rst_ifid", 32'(if_id_write), 1);
`ifdef ID_EX_PERF_CNT_EN
        chk("rst_scnt", stall_count, 0);
        chk("rst_fcnt", flush_count, 0);
`endif
        reset = 1'b0;

        // load-use on rs
        drv_lw(5'd2, 5'd8, 32'h100);
        #1 chk("lw_nostall", 32'(load_use_stall), 0);
        tick();
        chk("lw_valid", 32'(id_ex_valid), 1);
        chk("lw_wr", 32'(id_ex_write_reg_addr), 8);
        chk("lw_mr", 32'(id_ex_mem_read), 1);
        chk("lw_rs", 32'(id_ex_instr_rs), 2);
        chk("lw_imm", id_ex_imm, 32'h100);
        drv_add(5'd8, 5'd3, 5'd10);
        #1;
        chk("lu_stall", 32'(load_use_stall), 1);
        chk("lu_pcw", 32'(pc_write), 0);
        chk("lu_ifid", 32'(if_id_write), 0);
        tick();
        chk("lu_bub_valid", 32'(id_ex_valid), 0);
        chk("lu_bub_rw", 32'(id_ex_reg_write), 0);
        chk("lu_bub_rs", 32'(id_ex_instr_rs), 0);
        chk("lu_bub_wr", 32'(id_ex_write_reg_addr), 0);
        chk("lu_bub_stall", 32'(load_use_stall), 0);
        chk("lu_bub_pcw", 32'(pc_write), 1);
        tick();
        chk("lu_add_rs", 32'(id_ex_instr_rs), 8);
        chk("lu_add_rt", 32'(id_ex_instr_rt), 3);
        chk("lu_add_wr", 32'(id_ex_write_reg_addr), 10);
        chk("lu_add_rw", 32'(id_ex_reg_write), 1);
        chk("lu_add_rsd", id_ex_rs_data, 32'hDEAD_0008);

        // rt not used as source
        drv_lw(5'd1, 5'd8, 32'h4);
        tick();
        drv_addi(5'd4, 5'd8, 32'h7);
        #1;
        chk("rtun_stall", 32'(load_use_stall), 0);
        chk("rtun_pcw", 32'(pc_write), 1);
        tick();
        chk("rtun_wr", 32'(id_ex_write_reg_addr), 8);
        chk("rtun_rs", 32'(id_ex_instr_rs), 4);
        chk("rtun_imm", id_ex_imm, 32'h7);

        // rt used as source
        drv_lw(5'd1, 5'd8, 32'h0);
        tick();
        drv_add(5'd1, 5'd8, 5'd12);
        #1 chk("rtuse_stall", 32'(load_use_stall), 1);
        tick();
        chk("rtuse_bub", 32'(id_ex_valid), 0);
        tick();
        chk("rtuse_wr", 32'(id_ex_write_reg_addr), 12);

        // load to $0 never stalls
        drv_lw(5'd5, 5'd0, 32'h0);
        tick();
        chk("z_mr", 32'(id_ex_mem_read), 1);
        drv_add(5'd0, 5'd0, 5'd7);
        #1 chk("z_stall", 32'(load_use_stall), 0);
        tick();
        chk("z_wr", 32'(id_ex_write_reg_addr), 7);

        // empty ID slot captures as a bubble
        drv_add(5'd6, 5'd6, 5'd6);
        id_valid = 1'b0;
        tick();
        chk("nv_valid", 32'(id_ex_valid), 0);
        chk("nv_rs", 32'(id_ex_instr_rs), 0);
        chk("nv_rw", 32'(id_ex_reg_write), 0);

        // flush coinciding with load-use
        drv_lw(5'd2, 5'd8, 32'h0);
        tick();
        drv_add(5'd8, 5'd3, 5'd10);
        ex_flush = 1'b1;
        #1;
        chk("fl_pcw", 32'(pc_write), 1);
        chk("fl_ifid", 32'(if_id_write), 1);
        tick();
        chk("fl_valid", 32'(id_ex_valid), 0);
        chk("fl_rs", 32'(id_ex_instr_rs), 0);
        chk("fl_wr", 32'(id_ex_write_reg_addr), 0);
        chk("fl_mr", 32'(id_ex_mem_read), 0);
`ifdef ID_EX_PERF_CNT_EN
        chk("fl_scnt", stall_count, 2);
        chk("fl_fcnt", flush_count, 1);
`endif
        ex_flush = 1'b0;
        tick();
        chk("fl_next_rs", 32'(id_ex_instr_rs), 8);
        chk("fl_next_wr", 32'(id_ex_write_reg_addr), 10);

        // pipe_hold for three cycles
        drv_sub(5'd9, 5'd4, 5'd11);
        tick();
        chk("h_sub_rs", 32'(id_ex_instr_rs), 9);
        pipe_hold = 1'b1;
        drv_add(5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("h_pcw", 32'(pc_write), 0);
            chk("h_ifid", 32'(if_id_write), 0);
            tick();
            chk("h_rs", 32'(id_ex_instr_rs), 9);
            chk("h_wr", 32'(id_ex_write_reg_addr), 11);
            chk("h_op", 32'(id_ex_alu_op), 1);
        end
        pipe_hold = 1'b0;
        #1 chk("h_rel_pcw", 32'(pc_write), 1);
        tick();
        chk("h_adv_rs", 32'(id_ex_instr_rs), 1);
        chk("h_adv_wr", 32'(id_ex_write_reg_addr), 3);
        chk("h_adv_op", 32'(id_ex_alu_op), 0);

        // reset in the middle of a stall
        drv_lw(5'd2, 5'd8, 32'h0);
        tick();
        drv_add(5'd8, 5'd3, 5'd10);
        #1 chk("rs_pre_stall", 32'(load_use_stall), 1);
        reset = 1'b1;
        #1;
        chk("rs_stall", 32'(load_use_stall), 0);
        chk("rs_pcw", 32'(pc_write), 1);
        chk("rs_ifid", 32'(if_id_write), 1);
        tick();
        chk("rs_valid", 32'(id_ex_valid), 0);
        chk("rs_rs", 32'(id_ex_instr_rs), 0);
        chk("rs_mr", 32'(id_ex_mem_read), 0);
        chk("rs_pc4", id_ex_pc_plus4, 0);
`ifdef ID_EX_PERF_CNT_EN
        chk("rs_scnt", stall_count, 0);
        chk("rs_fcnt", flush_count, 0);
`endif
        reset = 1'b0;
        drv_add(5'd3, 5'd4, 5'd5);
        #1 chk("rs_rel_stall", 32'(load_use_stall), 0);
        tick();
        chk("rs_rel_valid", 32'(id_ex_valid), 1);
        chk("rs_rel_rs", 32'(id_ex_instr_rs), 3);
        chk("rs_rel_wr", 32'(id_ex_write_reg_addr), 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
